// File: rtl/ps2_cmd_ctrl.sv
// PS/2 "Set LEDs" command sequencer.
// Sends 0xED followed by the LED mask, waits for the keyboard ACK after each
// byte, retries on resend/timeout/transmit error, and shares the receive
// FIFO with the scan-code decoder. ACK/RESEND bytes are consumed only while
// an acknowledge is awaited; all other bytes pass through to the decoder.
module ps2_cmd_ctrl #(
  parameter logic [23:0] TIMEOUT   = 24'd1000000,
  parameter logic [1:0]  MAX_RETRY = 2'd2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_read_next,
  output logic       fwd_ready,
  output logic [7:0] fwd_data,
  input  logic       fwd_read_next
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_ACK1 = 3'd2,
    SEND_ARG  = 3'd3,
    WAIT_ACK2 = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_SET_LED = 8'hED;
  localparam logic [7:0]  RSP_ACK     = 8'hFA;
  localparam logic [7:0]  RSP_RESEND  = 8'hFE;
  localparam logic [23:0] TMO_LAST    = TIMEOUT - 24'd1;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  mask;
  logic [2:0]  pend_mask;
  logic        pending;
  logic [1:0]  retry_cnt;
  logic [23:0] tmo_cnt;

  logic        in_wait;
  logic        rsp_hit;
  logic        rsp_ack;
  logic        rsp_resend;
  logic        tmo_hit;
  logic        start;
  logic        retry_clr;
  logic        retry_inc;
  logic        fail;

  // FA/FE at the FIFO head belongs to us only while an ACK is awaited;
  // in every other state it is ordinary keyboard traffic.
  assign in_wait    = (state == WAIT_ACK1) || (state == WAIT_ACK2);
  assign rsp_hit    = in_wait && ((rx_data == RSP_ACK) || (rx_data == RSP_RESEND));
  assign rsp_ack    = rsp_hit && rx_ready && (rx_data == RSP_ACK);
  assign rsp_resend = rsp_hit && rx_ready && (rx_data == RSP_RESEND);
  assign tmo_hit    = in_wait && (tmo_cnt == TMO_LAST);

  assign fwd_data     = rx_data;
  assign fwd_ready    = rsp_hit ? 1'b0 : rx_ready;
  assign rx_read_next = rsp_hit ? rx_ready : (fwd_read_next && rx_ready);
  assign busy         = (state != IDLE) || pending;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Mask latch, coalescing of requests made while busy, retry and ACK-timeout counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask      <= 3'd0;
      pend_mask <= 3'd0;
      pending   <= 1'b0;
      retry_cnt <= 2'd0;
      tmo_cnt   <= 24'd0;
    end else begin
      if (start) mask <= led_req ? led_mask : pend_mask;
      // A request that arrives while a command is in flight (including the
      // cycle of its done/err pulse) is parked; only the newest mask survives.
      if (led_req && (state != IDLE)) begin
        pending   <= 1'b1;
        pend_mask <= led_mask;
      end else if (start) begin
        pending   <= 1'b0;
      end
      if (retry_clr)      retry_cnt <= 2'd0;
      else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
      // Waits are always entered from a SEND state, so the counter is already zero on entry.
      if (in_wait) tmo_cnt <= tmo_cnt + 24'd1;
      else         tmo_cnt <= 24'd0;
    end
  end

  // Next-state and output decode; all failures funnel into one retry/abandon decision
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    tx_req    = 1'b0;
    tx_byte   = 8'h00;
    start     = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (led_req || pending) begin
          start     = 1'b1;
          retry_clr = 1'b1;
          state_nxt = SEND_CMD;
        end
      end
      SEND_CMD: begin
        tx_req  = 1'b1;
        tx_byte = CMD_SET_LED;
        if (tx_done)     state_nxt = WAIT_ACK1;
        else if (tx_err) fail      = 1'b1;
      end
      WAIT_ACK1: begin
        if (rsp_ack) begin
          retry_clr = 1'b1;
          state_nxt = SEND_ARG;
        end else if (rsp_resend || tmo_hit) begin
          fail = 1'b1;
        end
      end
      SEND_ARG: begin
        tx_req  = 1'b1;
        tx_byte = {5'b0, mask};
        if (tx_done)     state_nxt = WAIT_ACK2;
        else if (tx_err) fail      = 1'b1;
      end
      WAIT_ACK2: begin
        if (rsp_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (rsp_resend || tmo_hit) begin
          fail = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (fail) begin
      if (retry_cnt < MAX_RETRY) begin
        retry_inc = 1'b1;
        state_nxt = ((state == SEND_CMD) || (state == WAIT_ACK1)) ? SEND_CMD : SEND_ARG;
      end else begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: a scripted transmitter/keyboard responder, a tagged
// receive FIFO that says which bytes are acknowledges meant for the sequencer,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_ps2_cmd_ctrl;

  localparam logic [23:0] TMO    = 24'd100;
  localparam logic [1:0]  MRETRY = 2'd2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       led_req = 1'b0;
  logic [2:0] led_mask = 3'd0;
  logic       busy, done, err, tx_req;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_read_next, fwd_ready;
  logic [7:0] fwd_data;
  logic       fwd_read_next = 1'b1;

  ps2_cmd_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(MRETRY)) dut (
    .clk(clk), .rstn(rstn), .led_req(led_req), .led_mask(led_mask),
    .busy(busy), .done(done), .err(err), .tx_req(tx_req), .tx_byte(tx_byte),
    .tx_done(tx_done), .tx_err(tx_err), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_read_next(rx_read_next), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .fwd_read_next(fwd_read_next)
  );

  initial forever #5 clk = ~clk;

  typedef enum int {R_FA, R_FE, R_NONE, R_TXERR} resp_t;
  // ack=1 marks a byte the keyboard sent in answer to a transmitted byte
  typedef struct packed {logic ack; logic [7:0] b;} rx_ent_t;

  rx_ent_t    rxq[$];
  resp_t      script[$];
  logic [7:0] txlog[$];
  logic [7:0] fwdlog[$];
  int         gaps[$];
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, txerr_cnt = 0;
  logic pop_now = 1'b0, s_tx_req = 1'b0, s_tx_done = 1'b0, s_tx_err = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int low_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the tagged-FIFO model, plus event logging
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("fwd_data", 32'(fwd_data), 32'(rx_data));
      if (rxq.size() > 0 && rxq[0].ack) begin
        chk("arb_ack_pop", 32'(rx_read_next), 32'd1);
        chk("arb_ack_fwd", 32'(fwd_ready), 32'd0);
      end else if (rxq.size() > 0) begin
        chk("arb_fwd", 32'(fwd_ready), 32'd1);
        chk("arb_pop", 32'(rx_read_next), 32'(fwd_read_next));
      end else begin
        chk("arb_empty_fwd", 32'(fwd_ready), 32'd0);
        chk("arb_empty_pop", 32'(rx_read_next), 32'd0);
      end
      chk("done_err_excl", 32'(done & err), 32'd0);
      if (prev_hold) begin
        chk("tx_req_held", 32'(tx_req), 32'd1);
        chk("tx_byte_stable", 32'(tx_byte), 32'(prev_byte));
      end
      prev_hold = tx_req && !tx_done && !tx_err;
      prev_byte = tx_byte;
      if (tx_req && tx_done) txlog.push_back(tx_byte);
      if (tx_req && tx_err) txerr_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (fwd_ready && fwd_read_next) fwdlog.push_back(fwd_data);
      pop_now   = rx_read_next && rx_ready;
      s_tx_req  = tx_req;
      s_tx_done = tx_done;
      s_tx_err  = tx_err;
      if (busy && !tx_req) low_run++;
      else begin
        if (low_run > 0) gaps.push_back(low_run);
        low_run = 0;
      end
    end else begin
      prev_hold = 1'b0;
      pop_now   = 1'b0;
      s_tx_req  = 1'b0;
      s_tx_done = 1'b0;
      s_tx_err  = 1'b0;
      low_run   = 0;
    end
  end

  // Transmitter + keyboard responder and receive FIFO driver
  initial begin
    int dly, resp_dly;
    resp_t cur, kind;
    dly = 0; resp_dly = 0; kind = R_NONE;
    forever begin
      @(posedge clk);
      #2;
      tx_done = 1'b0;
      tx_err  = 1'b0;
      if (pop_now && rxq.size() > 0) void'(rxq.pop_front());
      if (!rstn) begin
        dly = 0;
        resp_dly = 0;
      end else begin
        if (resp_dly > 0) begin
          resp_dly--;
          if (resp_dly == 0) begin
            if (kind == R_FA) rxq.push_back({1'b1, 8'hFA});
            else if (kind == R_FE) rxq.push_back({1'b1, 8'hFE});
          end
        end
        if (s_tx_req && !s_tx_done && !s_tx_err) begin
          dly++;
          if (dly == 3) begin
            dly = 0;
            if (script.size() > 0) cur = script.pop_front();
            else cur = R_FA;
            if (cur == R_TXERR) tx_err = 1'b1;
            else begin
              tx_done  = 1'b1;
              kind     = cur;
              resp_dly = 5;
            end
          end
        end else begin
          dly = 0;
        end
      end
      rx_ready = (rxq.size() > 0);
      rx_data  = rx_ready ? rxq[0].b : 8'h00;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] m);
    led_req  = 1'b1;
    led_mask = m;
    step();
    led_req  = 1'b0;
  endtask

  function automatic int evt(input int which);
    if (which == 0) return done_cnt;
    if (which == 1) return err_cnt;
    return txlog.size();
  endfunction

  task automatic wait_evt(input string name, input int which, input int target, input int bound);
    int k;
    k = 0;
    while (evt(which) < target && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no event after %0d cycles, needed count %0d", name, bound, target);
    end
  endtask

  task automatic clear_logs();
    txlog.delete(); fwdlog.delete(); gaps.delete(); script.delete();
    done_cnt = 0; err_cnt = 0; txerr_cnt = 0;
  endtask

  // bytes holds the expected sequence, first byte in the most significant used lane
  task automatic check_tx(input string name, input int n, input logic [31:0] bytes);
    chk({name, "_len"}, 32'(txlog.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < txlog.size())
        chk($sformatf("%s_b%0d", name, i), 32'(txlog[i]), 32'(bytes[8*(n-1-i) +: 8]));
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_busy"},    32'(busy),    32'd0);
    chk({name, "_done"},    32'(done),    32'd0);
    chk({name, "_err"},     32'(err),     32'd0);
    chk({name, "_tx_req"},  32'(tx_req),  32'd0);
    chk({name, "_tx_byte"}, 32'(tx_byte), 32'd0);
  endtask

  initial begin
    int k;
    #2 rstn = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rstn = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic command: mask 100 -> ED, 04
    clear_logs();
    script.push_back(R_FA); script.push_back(R_FA);
    request(3'b100);
    wait_evt("t1_wait_done", 0, 1, 500);
    repeat (3) step();
    check_tx("t1_tx", 2, 32'h0000ED04);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err_cnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Resend after ED: ED, ED, 04
    clear_logs();
    script.push_back(R_FE); script.push_back(R_FA); script.push_back(R_FA);
    request(3'b100);
    wait_evt("t2_wait_done", 0, 1, 500);
    repeat (3) step();
    check_tx("t2_tx", 3, 32'h00EDED04);
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_err", 32'(err_cnt), 32'd0);

    // No response: three ED attempts, each wait exactly TIMEOUT cycles, then err
    clear_logs();
    script.push_back(R_NONE); script.push_back(R_NONE); script.push_back(R_NONE);
    request(3'b100);
    wait_evt("t3_wait_err", 1, 1, 1000);
    repeat (3) step();
    check_tx("t3_tx", 3, 32'h00EDEDED);
    chk("t3_err", 32'(err_cnt), 32'd1);
    chk("t3_done", 32'(done_cnt), 32'd0);
    chk("t3_gap_count", 32'(gaps.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < gaps.size()) chk($sformatf("t3_gap%0d", i), 32'(gaps[i]), 32'd100);
    chk("t3_busy", 32'(busy), 32'd0);

    // Transmit error on the argument byte: retried, no err
    clear_logs();
    script.push_back(R_FA); script.push_back(R_TXERR); script.push_back(R_FA);
    request(3'b001);
    wait_evt("t4_wait_done", 0, 1, 500);
    repeat (3) step();
    check_tx("t4_tx", 2, 32'h0000ED01);
    chk("t4_txerr", 32'(txerr_cnt), 32'd1);
    chk("t4_done", 32'(done_cnt), 32'd1);
    chk("t4_err", 32'(err_cnt), 32'd0);

    // Scan code ahead of the ACK in WAIT_ACK1 is forwarded, ACK is not
    clear_logs();
    script.push_back(R_FA); script.push_back(R_FA);
    request(3'b100);
    wait_evt("t5_wait_ed", 2, 1, 500);
    rxq.push_back({1'b0, 8'h1C});
    wait_evt("t5_wait_done", 0, 1, 500);
    repeat (3) step();
    chk("t5_fwd_len", 32'(fwdlog.size()), 32'd1);
    if (fwdlog.size() > 0) chk("t5_fwd_byte", 32'(fwdlog[0]), 32'h1C);
    check_tx("t5_tx", 2, 32'h0000ED04);
    chk("t5_done", 32'(done_cnt), 32'd1);

    // Coalescing: 001, then 010 and 100 while busy -> second command sends 04
    clear_logs();
    repeat (4) script.push_back(R_FA);
    request(3'b001);
    step();
    request(3'b010);
    step();
    request(3'b100);
    wait_evt("t6_wait_done", 0, 2, 1000);
    repeat (3) step();
    check_tx("t6_tx", 4, 32'hED01ED04);
    chk("t6_done", 32'(done_cnt), 32'd2);
    chk("t6_err", 32'(err_cnt), 32'd0);

    // Request in the same cycle as done is kept as pending
    clear_logs();
    repeat (4) script.push_back(R_FA);
    request(3'b011);
    k = 0;
    while (k < 500) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL t7_done_wait: done not seen within %0d cycles", 500);
    end
    led_req  = 1'b1;
    led_mask = 3'b101;
    step();
    led_req  = 1'b0;
    chk("t7_pending_busy", 32'(busy), 32'd1);
    wait_evt("t7_wait_done", 0, 2, 1000);
    repeat (3) step();
    check_tx("t7_tx", 4, 32'hED03ED05);
    chk("t7_done", 32'(done_cnt), 32'd2);

    // Reset while waiting for the second ACK
    clear_logs();
    script.push_back(R_FA); script.push_back(R_NONE);
    request(3'b010);
    wait_evt("t8_wait_arg", 2, 2, 500);
    repeat (3) step();
    chk("t8_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_outputs_zero("t8_reset");
    step();
    step();
    rstn = 1'b1;
    step();
    chk("t8_no_done", 32'(done_cnt), 32'd0);
    chk("t8_no_err", 32'(err_cnt), 32'd0);
    rxq.push_back({1'b0, 8'hFA});
    repeat (3) step();
    chk("t8_fwd_len", 32'(fwdlog.size()), 32'd1);
    if (fwdlog.size() > 0) chk("t8_fwd_byte", 32'(fwdlog[0]), 32'hFA);
    clear_logs();
    script.push_back(R_FA); script.push_back(R_FA);
    request(3'b110);
    wait_evt("t8_wait_done", 0, 1, 500);
    repeat (3) step();
    check_tx("t8_tx", 2, 32'h0000ED06);
    chk("t8_done", 32'(done_cnt), 32'd1);
    chk("t8_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
